rtl_sdpram_fifo_ctrl: RTL

RTL_SDPRAM_FIFO_CTRL -- requirements
Module: rtl_sdpram_fifo_ctrl

---
 rtl/rtl_fifo_pkg.sv | 10 +
 rtl/rtl_sdpram.sv | 29 ++
 rtl/rtl_sdpram_fifo_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/rtl_fifo_pkg.sv
// rtl_fifo_pkg: read-latency, output-buffer depth and level-width helpers shared by the FIFO slice
package rtl_fifo_pkg;
  localparam int LVL_XW = 2;
  function automatic int rd_lat(input int pipe);
    return 1 + pipe;
  endfunction
  function automatic int obuf_depth(input int pipe);
    return rd_lat(pipe) + 2;
  endfunction
endpackage

// File: rtl/rtl_sdpram.sv
// rtl_sdpram: simple dual-port RAM, port A write, port B read with optional unconditional output register
module rtl_sdpram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 64,
  parameter int DOUTB_PIPELINE = 1
) (
  input  logic              clka,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  input  logic              clkb,
  input  logic              enb,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] doutb
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [DWIDTH-1:0] rd_q;
  always_ff @(posedge clka) if (wea) mem[addra] <= dina;
  always_ff @(posedge clkb) if (enb) rd_q <= mem[addrb];
  generate
    if (DOUTB_PIPELINE != 0) begin : g_pipe
      logic [DWIDTH-1:0] pipe_q;
      always_ff @(posedge clkb) pipe_q <= rd_q;
      assign doutb = pipe_q;
    end else begin : g_nopipe
      assign doutb = rd_q;
    end
  endgenerate
endmodule

// File: rtl/rtl_sdpram_fifo_ctrl.sv
// rtl_sdpram_fifo_ctrl: first-word fall-through FIFO sequencing one SDP RAM, with an output buffer
// sized to absorb every in-flight read so the RAM output register never needs a stall.
module rtl_sdpram_fifo_ctrl
  import rtl_fifo_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 64,
  parameter int DOUTB_PIPELINE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DWIDTH-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DWIDTH-1:0]        m_data,
  output logic [AWIDTH+LVL_XW-1:0] level
);
  localparam int L  = rd_lat(DOUTB_PIPELINE);
  localparam int OD = obuf_depth(DOUTB_PIPELINE);
  localparam int OW = $clog2(OD + 1);
  localparam int PW = $clog2(OD);
  localparam int CW = AWIDTH + 1;
  localparam int LW = AWIDTH + LVL_XW;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
  logic [L-1:0]      vld_q, vld_d;
  logic [OW-1:0]     ob_cnt_q, ob_cnt_d, inflight;
  logic [PW-1:0]     ob_hd_q, ob_hd_d, ob_tl_q, ob_tl_d;
  logic [DWIDTH-1:0] ob_q [OD];
  logic [DWIDTH-1:0] doutb;
  logic              wr, rd, pop, cap;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + OW'(vld_q[i]);
    s_ready   = !ram_cnt_q[AWIDTH];
    m_valid   = ob_cnt_q != '0;
    m_data    = ob_q[ob_hd_q];
    level     = LW'(ram_cnt_q) + LW'(inflight) + LW'(ob_cnt_q);
    wr        = s_valid && s_ready && !flush;
    pop       = m_valid && m_ready;
    cap       = vld_q[L-1];
    rd        = !flush && ram_cnt_q != '0 && (inflight + ob_cnt_q - OW'(pop)) < OW'(OD);
    wr_ptr_d  = flush ? '0 : wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = flush ? '0 : rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_cnt_d = flush ? '0 : ram_cnt_q + CW'(wr) - CW'(rd);
    vld_d     = flush ? '0 : L'({vld_q, rd});
    ob_cnt_d  = flush ? '0 : ob_cnt_q + OW'(cap) - OW'(pop);
    ob_hd_d   = flush ? '0 : pop ? (ob_hd_q == PW'(OD - 1) ? '0 : ob_hd_q + 1'b1) : ob_hd_q;
    ob_tl_d   = flush ? '0 : cap ? (ob_tl_q == PW'(OD - 1) ? '0 : ob_tl_q + 1'b1) : ob_tl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      vld_q     <= '0;
      ob_cnt_q  <= '0;
      ob_hd_q   <= '0;
      ob_tl_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      vld_q     <= vld_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_hd_q   <= ob_hd_d;
      ob_tl_q   <= ob_tl_d;
    end
  end
  // RAM output has no enable, so the word arriving L cycles after issue must be taken now
  always_ff @(posedge clk) if (cap) ob_q[ob_tl_q] <= doutb;
  rtl_sdpram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DOUTB_PIPELINE(DOUTB_PIPELINE)) u_ram (
    .clka(clk), .wea(wr), .addra(wr_ptr_q), .dina(s_data),
    .clkb(clk), .enb(rd), .addrb(rd_ptr_q), .doutb(doutb)
  );
endmodule
